// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit ALU controller: widths, instruction
// field positions, FSM state encoding and the instruction decode helper.
package cpu8_pkg;

    localparam int DATA_W   = 8;
    localparam int INSTR_W  = 10;
    localparam int OP_W     = 3;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 4;

    localparam int LDI_BIT  = 9;
    localparam int OP_MSB   = 8;
    localparam int OP_LSB   = 6;
    localparam int RD_MSB   = 5;
    localparam int RD_LSB   = 4;
    localparam int RS1_MSB  = 3;
    localparam int RS1_LSB  = 2;
    localparam int RS2_MSB  = 1;
    localparam int RS2_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    typedef struct packed {
        logic              ldi;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.ldi = raw[LDI_BIT];
        d.op  = raw[OP_MSB:OP_LSB];
        d.rd  = raw[RD_MSB:RD_LSB];
        d.rs1 = raw[RS1_MSB:RS1_LSB];
        d.rs2 = raw[RS2_MSB:RS2_LSB];
        return d;
    endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Four 8-bit general-purpose registers: one synchronous write port and
// three asynchronous read ports (two operands plus debug).
module reg_file_4x8
    import cpu8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic [REG_AW-1:0] raddr_c,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/alu_ctrl_8bit.sv
// Sequencer for an external 8-bit ALU: fetches operands from a 4x8 register
// file, captures the ALU result and flags, and writes the result back.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | instr_ready=1, waiting for an instruction offer
// ST_READ  | operands and op registered onto the ALU inputs (skipped for ldi)
// ST_EXEC  | ALU result (or immediate) and flags captured
// ST_WRITE | done pulse; result written to r[rd] at the end of the cycle
module alu_ctrl_8bit
    import cpu8_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  instr_imm,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_carry,
    output logic [DATA_W-1:0]  result,
    output logic               carry_flag,
    output logic               zero_flag,
    output logic               done,
    output logic               busy,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t            state;
    state_t            state_nxt;
    instr_t            ir;
    logic [DATA_W-1:0] imm_q;
    logic              accept;
    logic              rf_we;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        rf_we       = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                done      = 1'b1;
                rf_we     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign accept = instr_valid && instr_ready;

    // Operands are read in READ, before this instruction's own write-back,
    // so rd aliasing rs1/rs2 naturally sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir         <= '0;
            imm_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            result     <= '0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            if (accept) begin
                ir    <= decode_instr(instr);
                imm_q <= instr_imm;
            end
            if (state == ST_READ && !ir.ldi) begin
                alu_a   <= rs1_data;
                alu_b   <= rs2_data;
                alu_sel <= ir.op;
            end
            if (state == ST_EXEC) begin
                if (ir.ldi) begin
                    result    <= imm_q;
                    zero_flag <= (imm_q == '0);
                end else begin
                    result     <= alu_out;
                    carry_flag <= alu_carry;
                    zero_flag  <= (alu_out == '0);
                end
            end
        end
    end

    reg_file_4x8 u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (ir.rd),
        .wdata   (result),
        .raddr_a (ir.rs1),
        .raddr_b (ir.rs2),
        .raddr_c (dbg_addr),
        .rdata_a (rs1_data),
        .rdata_b (rs2_data),
        .rdata_c (dbg_data)
    );

endmodule

// File: doc/alu_ctrl_8bit.md
ALU_CTRL_8BIT -- requirements
Module: alu_ctrl_8bit

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: instr_valid  input  1  instruction offered.
REQ-004 SHALL have ports: instr_ready  output  1  controller accepts instruction this cycle.
REQ-005 SHALL have ports: instr  input  10  {ldi[9], op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}.
REQ-006 SHALL have ports: instr_imm  input  8  immediate for ldi=1.
REQ-007 SHALL have ports: alu_a, alu_b  output  8  registered operands to external alu_8bit.
REQ-008 SHALL have ports: alu_sel  output  3  registered op to external alu_8bit.
REQ-009 SHALL have ports: alu_out  input  8, alu_carry  input  1  combinational ALU result.
REQ-010 SHALL have ports: result  output  8  last result; carry_flag, zero_flag  output  1.
REQ-011 SHALL have ports: done  output  1  one-cycle completion pulse; busy  output  1  = not IDLE.
REQ-012 SHALL have ports: dbg_addr  input  2, dbg_data  output  8  combinational register-file read.

Function
REQ-013 SHALL hold a 4x8 register file r0..r3; all registers general purpose.
REQ-014 SHALL use FSM states IDLE, READ, EXEC, WRITE, in that order, one cycle each except IDLE.
REQ-015 SHALL drive instr_ready=1 only in IDLE; accept on instr_valid&&instr_ready, latch instr/instr_imm, go READ.
REQ-016 SHALL ignore instr_valid outside IDLE; an offer persisting while busy is accepted on the next IDLE cycle.
REQ-017 READ: alu_a<=r[rs1], alu_b<=r[rs2], alu_sel<=op; go EXEC.
REQ-018 EXEC: result<=alu_out, carry_flag<=alu_carry, zero_flag<=(alu_out==0); go WRITE.
REQ-019 ldi=1: EXEC sets result<=imm, zero_flag<=(imm==0), carry_flag unchanged; alu_a/alu_b/alu_sel unchanged in READ.
REQ-020 WRITE: done=1 for exactly this cycle with result/flags already updated; r[rd]<=result at end of cycle; go IDLE.
REQ-021 Latency: accept edge E0 -> done high in cycle after E2 -> r[rd] updated at E3; next accept no earlier than E4 (4 cycles/instruction).
REQ-022 rd equal to rs1/rs2 SHALL read pre-write values; back-to-back dependent instructions SHALL see prior write (no hazard).
REQ-023 dbg_data SHALL equal r[dbg_addr] combinationally, reflecting writes from the following cycle.
REQ-024 Arithmetic is entirely in the external ALU; the controller SHALL not modify alu_out width or value.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE; r0..r3, alu_a, alu_b, alu_sel, result, carry_flag, zero_flag, done := 0.
REQ-026 Reset mid-instruction SHALL abort it: no done, no register write; instr_ready=1 in first cycle after rst_n returns high.

Structure
REQ-027 Instruction field positions, state encoding and widths SHALL live in shared package cpu8_pkg.
REQ-028 Register file SHALL be sub-module reg_file_4x8 (1 sync write, 3 async read ports); ALU remains external alu_8bit.

Verification
REQ-029 Bench ALU model: sel 000 = a+b with carry; connected to alu_* ports.
REQ-030 Reset: hold rst_n=0 2 cycles -> all outputs 0, dbg_data=0 for all addresses, instr_ready=1 after release.
REQ-031 LDI r1=0x6F, LDI r2=0x6F, ADD r3=r1+r2 -> result=0xDE, carry 0, zero 0, done 3 cycles after accept, dbg r3=0xDE.
REQ-032 LDI r0=0xFF, LDI r1=0x01, ADD r2=r0+r1 -> result=0x00, carry_flag=1, zero_flag=1, r2=0x00.
REQ-033 LDI r1=0x40, ADD r1=r1+r1 -> r1=0x80; then ADD r1=r1+r1 -> r1=0x00, carry 1.
REQ-034 instr_valid held high 12 cycles -> exactly 3 accepts, 4 cycles apart, instr_ready low while busy.
REQ-035 rst_n=0 during EXEC of ADD r3 -> no done pulse, r3=0, flags 0, next instruction accepted normally.
